// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the video-memory pixel-write port between two
// round-robin requesters and a full-screen clear engine. The clear engine
// preempts both requesters while it runs.
// Optional build macro VGA_PLOT_VBLANK_ONLY_EN: when defined, writes are
// issued only while in_vblank is high.
module vga_plot_arbiter #(
  parameter int X_MAX = 319,
  parameter int Y_MAX = 239,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3,
  parameter logic [CW-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic          vga_clock,
  input  logic          resetn,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [XW-1:0] r0_x,
  input  logic [YW-1:0] r0_y,
  input  logic [CW-1:0] r0_colour,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [XW-1:0] r1_x,
  input  logic [YW-1:0] r1_y,
  input  logic [CW-1:0] r1_colour,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  input  logic          in_vblank,
  output logic          plot,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, FINISH = 2'd2} state_t;

  localparam logic [XW-1:0] XLAST = XW'(X_MAX);
  localparam logic [YW-1:0] YLAST = YW'(Y_MAX);

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic            plot_q, plot_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   colour_q, colour_d;
  logic            wr_ok;
  logic            gnt0, gnt1, clr_issue;

`ifdef VGA_PLOT_VBLANK_ONLY_EN
  // Writes only land while scan-out is outside the visible area (tear-free).
  assign wr_ok = in_vblank;
`else
  logic unused_in_vblank;
  assign unused_in_vblank = in_vblank;
  assign wr_ok = 1'b1;
`endif

  // Next-state: arbitration in IDLE, clear raster scan in CLEAR, done pulse in FINISH.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    clr_issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          // Clear wins over any pending request; no grant this cycle.
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (wr_ok) begin
          gnt0 = r0_valid && (!r1_valid || last_grant_q);
          gnt1 = r1_valid && (!r0_valid || !last_grant_q);
          if (gnt0) begin
            plot_d       = 1'b1;
            x_d          = r0_x;
            y_d          = r0_y;
            colour_d     = r0_colour;
            last_grant_d = 1'b0;
          end else if (gnt1) begin
            plot_d       = 1'b1;
            x_d          = r1_x;
            y_d          = r1_y;
            colour_d     = r1_colour;
            last_grant_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (wr_ok) begin
          clr_issue = 1'b1;
          if (cx_q == XLAST) begin
            cx_d = '0;
            if (cy_q == YLAST) state_d = FINISH;
            else               cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered grant payload; async active-low reset.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cx_q         <= '0;
      cy_q         <= '0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
    end
  end

  // Clear pixels come straight from the counter so the first one appears
  // in the same cycle clear_busy rises; grants come from the register.
  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign plot       = plot_q | clr_issue;
  assign x          = (state_q == CLEAR) ? cx_q : x_q;
  assign y          = (state_q == CLEAR) ? cy_q : y_q;
  assign colour     = (state_q == CLEAR) ? CLEAR_COLOUR : colour_q;
  assign clear_busy = (state_q != IDLE);
  assign clear_done = (state_q == FINISH);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter on a reduced 16x10 grid.
module tb_vga_plot_arbiter;

  localparam int XM = 15;
  localparam int YM = 9;
  localparam int NPIX = (XM + 1) * (YM + 1);

  logic       vga_clock = 1'b0;
  logic       resetn;
  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [8:0] r0_x, r1_x, x;
  logic [7:0] r0_y, r1_y, y;
  logic [2:0] r0_colour, r1_colour, colour;
  logic       clear_start, clear_busy, clear_done, in_vblank, plot;

  int nvec = 0;
  int nmis = 0;

  vga_plot_arbiter #(.X_MAX(XM), .Y_MAX(YM), .XW(9), .YW(8), .CW(3),
                     .CLEAR_COLOUR(3'b000)) dut (
    .vga_clock(vga_clock), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y),
    .r0_colour(r0_colour),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y),
    .r1_colour(r1_colour),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .in_vblank(in_vblank), .plot(plot), .x(x), .y(y), .colour(colour)
  );

  always #5 vga_clock = ~vga_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, ey, npl, ndone, dc, lpc, bad, brdy, lx, ly;
    bit fin, hit;
    resetn = 1'b0;
    r0_valid = 0; r1_valid = 0; clear_start = 0; in_vblank = 1;
    r0_x = 0; r0_y = 0; r0_colour = 0; r1_x = 0; r1_y = 0; r1_colour = 0;
    repeat (2) @(posedge vga_clock);
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    resetn = 1'b1;

    // Single r0 write (5,7,5)
    tick();
    r0_valid = 1; r0_x = 5; r0_y = 7; r0_colour = 3'b101;
    #1;
    chk("t1_r0_ready", r0_ready, 1);
    chk("t1_r1_ready", r1_ready, 0);
    tick();
    r0_valid = 0;
    chk("t1_plot", plot, 1);
    chk("t1_x", x, 5);
    chk("t1_y", y, 7);
    chk("t1_colour", colour, 5);
    tick();
    chk("t1_plot_low", plot, 0);

    // Both valid for 4 cycles from fresh reset: r0, r1, r0, r1
    do_reset();
    tick();
    r0_valid = 1; r0_x = 1; r0_y = 2; r0_colour = 3'd1;
    r1_valid = 1; r1_x = 3; r1_y = 4; r1_colour = 3'd6;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_r0_ready", r0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_r1_ready", r1_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      if (i == 3) begin
        r0_valid = 0;
        r1_valid = 0;
      end
      chk("t2_plot", plot, 1);
      chk("t2_x", x, (i % 2 == 0) ? 1 : 3);
      chk("t2_y", y, (i % 2 == 0) ? 2 : 4);
      chk("t2_colour", colour, (i % 2 == 0) ? 1 : 6);
      #1;
    end
    tick();
    chk("t2_plot_low", plot, 0);

    // Full clear with r1 pending, plus a stray clear_start mid-clear
    tick();
    clear_start = 1;
    r1_valid = 1; r1_x = 9; r1_y = 8; r1_colour = 3'd2;
    #1;
    chk("t3_start_r1_ready", r1_ready, 0);
    tick();
    clear_start = 0;
    chk("t3_busy_rise", clear_busy, 1);
    chk("t3_first_plot", plot, 1);
    chk("t3_first_x", x, 0);
    chk("t3_first_y", y, 0);
    ex = 0; ey = 0; npl = 0; ndone = 0; dc = -1; lpc = -2; bad = 0; brdy = 0;
    lx = -1; ly = -1; fin = 0;
    for (int c = 0; c < NPIX + 20; c++) begin
      if (!clear_busy) begin
        fin = 1;
        break;
      end
      if (plot) begin
        if (x !== 9'(ex) || y !== 8'(ey) || colour !== 3'd0) bad++;
        lx = int'(x); ly = int'(y); lpc = c; npl++;
        if (ex == XM) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      if (clear_done) begin
        ndone++;
        dc = c;
      end
      if (r1_ready) brdy++;
      clear_start = (c == 40);
      tick();
    end
    clear_start = 0;
    chk("t3_finished", fin, 1);
    chk("t3_plot_count", npl, NPIX);
    chk("t3_pixel_order_errs", bad, 0);
    chk("t3_last_x", lx, XM);
    chk("t3_last_y", ly, YM);
    chk("t3_done_count", ndone, 1);
    chk("t3_done_after_last", dc, lpc + 1);
    chk("t3_r1_ready_during_clear", brdy, 0);
    chk("t3_r1_ready_after", r1_ready, 1);
    tick();
    r1_valid = 0;
    chk("t3_r1_plot", plot, 1);
    chk("t3_r1_x", x, 9);
    chk("t3_r1_y", y, 8);
    chk("t3_r1_colour", colour, 2);

    // Reset asserted at clear pixel (10,2)
    tick();
    clear_start = 1;
    #1;
    tick();
    clear_start = 0;
    hit = 0;
    for (int c = 0; c < NPIX; c++) begin
      if (plot && x == 9'd10 && y == 8'd2) begin
        resetn = 1'b0;
        #1;
        hit = 1;
        break;
      end
      tick();
    end
    chk("t4_hit_pixel", hit, 1);
    chk("t4_plot", plot, 0);
    chk("t4_x", x, 0);
    chk("t4_y", y, 0);
    chk("t4_colour", colour, 0);
    chk("t4_busy", clear_busy, 0);
    chk("t4_done", clear_done, 0);
    tick();
    resetn = 1'b1;
    r0_valid = 1; r0_x = 4; r0_y = 3; r0_colour = 3'd7;
    #1;
    chk("t4_r0_ready", r0_ready, 1);
    tick();
    r0_valid = 0;
    chk("t4_plot_after", plot, 1);
    chk("t4_x_after", x, 4);
    chk("t4_colour_after", colour, 7);

`ifdef VGA_PLOT_VBLANK_ONLY_EN
    // Requests stall outside vblank
    tick();
    in_vblank = 0;
    r0_valid = 1; r0_x = 6; r0_y = 1; r0_colour = 3'd3;
    brdy = 0; npl = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (r0_ready) brdy++;
      if (plot) npl++;
      tick();
    end
    chk("t5_ready_out_vblank", brdy, 0);
    chk("t5_plot_out_vblank", npl, 0);
    in_vblank = 1;
    #1;
    chk("t5_ready_in_vblank", r0_ready, 1);
    tick();
    r0_valid = 0;
    chk("t5_plot", plot, 1);
    chk("t5_x", x, 6);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Arbitrates the single pixel-write port of the video memory between two drawing requesters and an internal full-screen clear engine. It sits upstream of the video-memory write side (x, y, colour, plot), while the scan-out controller reads the same memory through its independent read port. It delivers at most one pixel write per `vga_clock` cycle, using round-robin fairness between requesters. A clear request preempts both requesters until the clear completes.

## Interface
Parameters:
- `X_MAX`, default 319: last x coordinate (320x240 dot grid).
- `Y_MAX`, default 239: last y coordinate.
- `XW`, default 9: x width in bits.
- `YW`, default 8: y width in bits.
- `CW`, default 3: colour width (`BITS_PER_COLOUR_CHANNEL`*3).
- `CLEAR_COLOUR`, default 3'b000: colour written by the clear engine.

Ports:
- `vga_clock` in 1: clock; all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `r0_valid`, `r1_valid` in 1: requester has a pixel to write.
- `r0_ready`, `r1_ready` out 1: grant; transfer when valid&&ready.
- `r0_x`, `r1_x` in XW; `r0_y`, `r1_y` in YW; `r0_colour`, `r1_colour` in CW: request payloads.
- `clear_start` in 1: one-cycle pulse to start the screen clear.
- `clear_busy` out 1: clear in progress.
- `clear_done` out 1: one-cycle pulse after the last clear pixel is issued.
- `in_vblank` in 1: scan-out is outside the visible area.
- `plot` out 1: write strobe to video memory.
- `x` out XW; `y` out YW; `colour` out CW: write address and data.

## Operation
- FSM states:
  - IDLE: arbitrates the two requesters.
  - CLEAR: issues clear writes.
  - FINISH: one cycle; pulses `clear_done`.
- IDLE -> CLEAR on `clear_start`. On entry the counters load cx=0, cy=0.
- CLEAR -> FINISH when the pixel at (X_MAX, Y_MAX) is issued. FINISH -> IDLE unconditionally.
- `clear_start` is ignored in CLEAR and FINISH. If `clear_start` and a requester valid are both present in IDLE, clear wins: no grant that cycle, and the FSM enters CLEAR.
- Clear scan order: x increments from 0 to X_MAX. At X_MAX, x wraps to 0 and y increments. Total of (X_MAX+1)*(Y_MAX+1) writes (76800 at defaults).
- Readiness:
  - `r0_ready` and `r1_ready` are 0 in CLEAR and FINISH.
  - In IDLE, at most one ready is high, and only toward a valid requester.
  - Ready is combinational from `rN_valid`, the state, and `last_grant`.
- Round-robin arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not in `last_grant` is granted.
  - `last_grant` updates on each completed transfer. Its reset value is 1, so r0 wins the first tie.
- Requesters must hold valid and payload stable until ready. Dropping valid without a transfer is a protocol violation; behaviour in that case is unspecified.
- A granted payload is registered onto `x`/`y`/`colour` with `plot`=1. Clear writes drive `CLEAR_COLOUR`.
- Coordinates are passed through unmodified. There is no range check; address translation happens downstream.

## Timing
- Reset values:
  - `plot`=0, `x`=0, `y`=0, `colour`=0.
  - `clear_busy`=0, `clear_done`=0.
  - State IDLE; `last_grant`=1; both readys 0.
- Latency: handshake in cycle N gives `plot` high in cycle N+1 with the payload. The output is held for exactly one cycle, and `plot` is 0 in any cycle without an issued write.
- Throughput is 1 write/cycle, both during back-to-back grants and during clear.
- `clear_busy` rises the cycle after `clear_start` and stays high through CLEAR and FINISH. The first clear `plot` appears in the same cycle `clear_busy` rises.
- `clear_done` is high for the single FINISH cycle, one cycle after the final clear `plot`. `clear_busy` drops the following cycle.
- When `resetn` is asserted mid-clear, state, counters and outputs return to their reset values immediately. The clear is not resumed.

## Configuration
- `VGA_PLOT_VBLANK_ONLY_EN` defined:
  - Both requester grants and clear writes occur only in cycles where `in_vblank`=1.
  - When `in_vblank`=0, readys are 0 and the clear counters hold. CLEAR→FINISH occurs only on the cycle the (X_MAX, Y_MAX) pixel is actually issued.
  - This gives tear-free updates.
- Undefined: `in_vblank` is ignored (the port remains), and writes proceed every cycle.

## Test plan
- Reset, then r0_valid=1 with (5,7,3'b101) → `r0_ready`=1 in the same cycle; next cycle `plot`=1, x=5, y=7, colour=5; the cycle after, `plot`=0.
- r0 and r1 held valid for 4 cycles → grants r0, r1, r0, r1; `plot` high 4 consecutive cycles with alternating payloads.
- `clear_start` pulse with r1_valid=1 → r1_ready=0 throughout; 76800 `plot` pulses with colour 0, the first at (0,0) and the last at (319,239); `clear_done` the next cycle; then r1 is granted.
- `resetn` dropped at clear pixel (10,2) → all outputs 0 and `clear_busy`=0 immediately; after release, r0_valid=1 is granted the first clock.
- With `VGA_PLOT_VBLANK_ONLY_EN`, r0_valid=1 and in_vblank=0 for 20 cycles → no ready and no plot; in_vblank=1 → grant that cycle, plot the next.
- `clear_start` pulsed again mid-clear → ignored; total writes are still exactly 76800 and there is a single `clear_done`.
